// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit and its divider
package mdu_pkg;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} div_state_t;
  typedef enum logic [2:0] {OP_DIV, OP_DIVU, OP_MULT, OP_MULTU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO} mdu_op_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration, shifting in the next dividend bit
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_next_rem,
  output logic             o_q_bit
);
  logic [WIDTH:0] w_trial;
  // trial subtract one bit wider than the operands so its sign decides the quotient bit
  always_comb begin
    w_trial    = {i_rem, i_q_msb} - {1'b0, i_dvs};
    o_q_bit    = ~w_trial[WIDTH];
    o_next_rem = o_q_bit ? w_trial[WIDTH-1:0] : {i_rem[WIDTH-2:0], i_q_msb};
  end
endmodule

// File: rtl/mdu_divider.sv
// mdu_divider: iterative signed/unsigned restoring divider producing quotient and remainder
module mdu_divider import mdu_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);
  localparam int CW = $clog2(WIDTH) + 1;
  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_q, r_dvs;
  logic             r_q_neg, r_r_neg;
  logic [WIDTH-1:0] w_dvd_abs, w_dvs_abs, w_next_rem;
  logic             w_q_bit, w_dvd_neg, w_dvs_neg;
  // magnitudes are taken as unsigned so the most negative value maps to itself
  always_comb begin
    w_dvd_neg = i_is_signed & i_dividend[WIDTH-1];
    w_dvs_neg = i_is_signed & i_divisor[WIDTH-1];
    w_dvd_abs = w_dvd_neg ? -i_dividend : i_dividend;
    w_dvs_abs = w_dvs_neg ? -i_divisor : i_divisor;
  end
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem      (r_rem),
    .i_q_msb    (r_q[WIDTH-1]),
    .i_dvs      (r_dvs),
    .o_next_rem (w_next_rem),
    .o_q_bit    (w_q_bit)
  );
  // control FSM: capture operands, iterate WIDTH times, then sign-fix into the result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_dvs       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_div_zero  <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          if (i_divisor == '0) begin
            o_done     <= 1'b1;
            o_div_zero <= 1'b1;
          end else begin
            r_state <= S_CALC;
            o_busy  <= 1'b1;
            r_cnt   <= CW'(WIDTH);
            r_rem   <= '0;
            r_q     <= w_dvd_abs;
            r_dvs   <= w_dvs_abs;
            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg <= w_dvd_neg;
          end
        end
        S_CALC: begin
          r_rem <= w_next_rem;
          r_q   <= {r_q[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          o_quotient  <= r_q_neg ? -r_q : r_q;
          o_remainder <= r_r_neg ? -r_rem : r_rem;
          o_done      <= 1'b1;
          o_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_divider.sv
// tb_mdu_divider: scoreboard bench for the iterative divider
module tb_mdu_divider;
  typedef struct packed {logic [31:0] q; logic [31:0] r; logic dz;} exp_t;
  logic clk = 0, reset = 1, start = 0, sgn = 0;
  logic [31:0] dvd = 0, dvs = 0;
  logic busy, done, div_zero;
  logic [31:0] quotient, remainder;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_err = 0;
  int n, bc;
  logic [31:0] m_q = 0, m_r = 0;

  mdu_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_is_signed(sgn),
    .i_dividend(dvd), .i_divisor(dvs), .o_busy(busy), .o_done(done),
    .o_div_zero(div_zero), .o_quotient(quotient), .o_remainder(remainder)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    if (b == 0) x = {m_q, m_r, 1'b1};
    else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) x = {a, 32'h0, 1'b0};
    else if (s) x = {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b)), 1'b0};
    else x = {a / b, a % b, 1'b0};
    return x;
  endfunction

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    sgn = s; dvd = a; dvs = b; start = 1;
    x = model(s, a, b);
    sb.push_back(x);
    m_q = x.q; m_r = x.r;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int n0, output int nn, output int bcnt);
    nn = n0; bcnt = 0;
    while (!done && nn < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      nn++;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({busy, done, div_zero} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {busy, done, div_zero}); end
    n_cmp++; if ({quotient, remainder} !== 64'h0) begin n_err++; $display("FAIL reset_results got %h want 0", {quotient, remainder}); end
    reset = 0;
  endtask

  task automatic test_unsigned();
    launch(0, 100, 7);
    wait_done(0, n, bc);
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL udiv_latency got %0d want 33", n); end
    n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL udiv_busy_cycles got %0d want 33", bc); end
    e = sb.pop_front();
    n_cmp++; if ({quotient, remainder, div_zero} !== e) begin n_err++; $display("FAIL udiv_100_7 got %h/%h/%b want %h/%h/%b", quotient, remainder, div_zero, e.q, e.r, e.dz); end
    n_cmp++; if ({quotient, remainder} !== {32'd14, 32'd2}) begin n_err++; $display("FAIL udiv_const got %0d/%0d want 14/2", quotient, remainder); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_signed();
    logic [64:0] tbl [4];
    tbl[0] = {1'b1, 32'hFFFF_FFF9, 32'd2};
    tbl[1] = {1'b1, 32'd7, 32'hFFFF_FFFE};
    tbl[2] = {1'b1, 32'h8000_0000, 32'hFFFF_FFFF};
    tbl[3] = {1'b0, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      launch(tbl[i][64], tbl[i][63:32], tbl[i][31:0]);
      wait_done(0, n, bc);
      e = sb.pop_front();
      n_cmp++; if ({quotient, remainder, div_zero} !== e) begin n_err++; $display("FAIL sdiv_%0d got %h/%h/%b want %h/%h/%b", i, quotient, remainder, div_zero, e.q, e.r, e.dz); end
    end
    n_cmp++; if ({quotient, remainder} !== {32'h0, 32'h8000_0000}) begin n_err++; $display("FAIL udiv_min_const got %h/%h want 00000000/80000000", quotient, remainder); end
  endtask

  task automatic test_div_zero();
    launch(0, 9, 4);
    wait_done(0, n, bc);
    e = sb.pop_front();
    n_cmp++; if ({quotient, remainder, div_zero} !== e) begin n_err++; $display("FAIL dz_pre got %h/%h/%b want %h/%h/%b", quotient, remainder, div_zero, e.q, e.r, e.dz); end
    launch(0, 5, 0);
    wait_done(0, n, bc);
    n_cmp++; if (n !== 0 || bc !== 0) begin n_err++; $display("FAIL dz_latency got %0d/%0d want 0/0", n, bc); end
    e = sb.pop_front();
    n_cmp++; if ({quotient, remainder, div_zero} !== e) begin n_err++; $display("FAIL dz_result got %h/%h/%b want %h/%h/%b", quotient, remainder, div_zero, e.q, e.r, e.dz); end
    n_cmp++; if ({quotient, remainder, div_zero} !== {32'd2, 32'd1, 1'b1}) begin n_err++; $display("FAIL dz_const got %0d/%0d/%b want 2/1/1", quotient, remainder, div_zero); end
    @(posedge clk); #1;
    n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL dz_after got %b want 00", {done, busy}); end
  endtask

  task automatic test_busy_ignore();
    launch(0, 1000, 10);
    repeat (9) @(posedge clk);
    #1;
    dvd = 3; dvs = 1; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(10, n, bc);
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL ignore_latency got %0d want 33", n); end
    e = sb.pop_front();
    n_cmp++; if ({quotient, remainder, div_zero} !== e) begin n_err++; $display("FAIL ignore_result got %h/%h/%b want %h/%h/%b", quotient, remainder, div_zero, e.q, e.r, e.dz); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] old_q;
    launch(1, 32'hFFFF_FF9C, 7);
    wait_done(0, n, bc);
    e = sb.pop_front();
    old_q = e.q;
    n_cmp++; if ({quotient, remainder, div_zero} !== e) begin n_err++; $display("FAIL b2b_first got %h/%h/%b want %h/%h/%b", quotient, remainder, div_zero, e.q, e.r, e.dz); end
    launch(0, 50, 3);
    n_cmp++; if ({busy, quotient} !== {1'b1, old_q}) begin n_err++; $display("FAIL b2b_hold got %b/%h want 1/%h", busy, quotient, old_q); end
    wait_done(0, n, bc);
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL b2b_latency got %0d want 33", n); end
    e = sb.pop_front();
    n_cmp++; if ({quotient, remainder, div_zero} !== e) begin n_err++; $display("FAIL b2b_second got %h/%h/%b want %h/%h/%b", quotient, remainder, div_zero, e.q, e.r, e.dz); end
  endtask

  task automatic test_reset_mid();
    int dones;
    launch(0, 12345, 3);
    repeat (14) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    sb.delete();
    m_q = 0; m_r = 0;
    n_cmp++; if ({busy, done, quotient, remainder} !== 66'h0) begin n_err++; $display("FAIL midreset_state got %b/%b/%h/%h want 0/0/0/0", busy, done, quotient, remainder); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL midreset_done got %0d want 0", dones); end
    launch(0, 32'hFFFF_FFFF, 1);
    wait_done(0, n, bc);
    e = sb.pop_front();
    n_cmp++; if ({quotient, remainder, div_zero} !== e) begin n_err++; $display("FAIL midreset_next got %h/%h/%b want %h/%h/%b", quotient, remainder, div_zero, e.q, e.r, e.dz); end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic s;
    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom();
      b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom();
      if (b == 0) b = 1;
      if (i % 3 == 0) b = -b;
      launch(s, a, b);
      wait_done(0, n, bc);
      e = sb.pop_front();
      n_cmp++; if ({quotient, remainder, div_zero} !== e || n !== 33) begin n_err++; $display("FAIL rand_%0d %h/%h s=%b got %h/%h/%b lat %0d want %h/%h/%b lat 33", i, a, b, s, quotient, remainder, div_zero, n, e.q, e.r, e.dz); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_divider.md
# mdu_divider

Iterative radix-2 restoring divider feeding the multiply/divide unit's HI/LO registers. It accepts one signed or unsigned 32-bit divide per start pulse and computes for WIDTH+1 cycles. It then presents the quotient (to LO) and remainder (to HI) with a one-cycle done pulse. It replaces the single-cycle `/` and `%` operators in E stage. The existing counter-based busy is retired in favour of this block's real busy.

## Interface
- WIDTH, 32, operand/result width in bits (fixed at 32 for MIPS; parameter kept for narrow-width simulation)
- clk  in  1  clock; every register updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = DIV semantics, 0 = DIVU; sampled with start
- dividend  in  WIDTH  rs value; sampled with start
- divisor  in  WIDTH  rt value; sampled with start
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; results are valid and updated in this cycle
- div_zero  out  1  qualifies done; high when divisor was 0
- quotient  out  WIDTH  registered quotient, held until the next completion
- remainder  out  WIDTH  registered remainder, held until the next completion

## Operation
- FSM states:
  - IDLE: start=1, divisor≠0 → CALC. start=1, divisor=0 → IDLE with done=1 and div_zero=1.
  - CALC: stays for WIDTH cycles, counter WIDTH→0, then → FIX.
  - FIX → IDLE with done=1.
- Capture on start:
  - If is_signed: store |dividend|, |divisor|, q_neg = sign(dividend)^sign(divisor), r_neg = sign(dividend).
  - Otherwise: store raw values, q_neg = r_neg = 0.
  - Absolute values are unsigned WIDTH-bit, so |−2^31| = 0x8000_0000.
- CALC iteration:
  - trial = {rem, q[WIDTH-1]} − {0, dvs}, computed WIDTH+1 bits wide.
  - q is shifted left each cycle.
  - If trial is non-negative: rem ← trial[WIDTH-1:0] and the new q LSB is 1.
  - Otherwise: rem ← {rem, q[WIDTH-1]}[WIDTH-1:0] and the new q LSB is 0.
- FIX: quotient ← q_neg ? −q : q; remainder ← r_neg ? −rem : rem. All arithmetic is modulo 2^WIDTH.
- Required results:
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Signed 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0. No trap.
- Divide by zero: quotient and remainder keep their previous values; the MIPS HI/LO-unchanged rule is met downstream.
- start while busy: ignored. No queueing and no error flag. The hazard unit must not issue it.
- done and div_zero are registered outputs, never combinational from inputs.

## Timing
- Reset values: state IDLE, busy 0, done 0, div_zero 0, quotient 0, remainder 0, internal counter and working registers 0.
- Edge E0 samples start. busy=1 from E0 through E(WIDTH+1). The CALC iterations occupy E1..E(WIDTH). Edge E(WIDTH+1) writes the results, sets done=1, clears busy.
  - Result visible WIDTH+1 cycles after start (33 for WIDTH=32).
- Divide by zero: done=1, div_zero=1 and busy=0 immediately after E0.
- done is high for exactly one cycle and is low in every other cycle.
- Back-to-back: start may be high in the same cycle done is high, because the FSM is in IDLE. The new operation begins at that edge and outputs stay at the old result until its own done.
- Reset mid-operation: on the next edge, abort to IDLE, busy 0, no done pulse, outputs cleared to 0.

## Structure
- Shared package mdu_pkg holds:
  - state encoding: IDLE, CALC, FIX
  - WIDTH default
  - MDU op codes (DIV, DIVU, MULT, MULTU, MFHI, MFLO, MTHI, MTLO), so the decoder, MDU and this block agree
- Sub-module div_step: purely combinational single iteration.
  - Inputs: rem, q_msb, dvs.
  - Outputs: next_rem, q_bit.
  - Instantiated once in CALC and unit-tested standalone.
- Top module holds the FSM, counter (clog2(WIDTH)+1 bits), operand/sign registers and output registers.

## Test plan
- Unsigned 100 / 7, start at cycle 0 → busy 1 for cycles 1–33, done at cycle 33, quotient 14, remainder 2, div_zero 0.
- Signed −7 / 2 → quotient 0xFFFF_FFFD (−3), remainder 0xFFFF_FFFF (−1). Signed 7 / −2 → quotient −3, remainder 1.
- Signed 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0. Same operands unsigned → quotient 0, remainder 0x8000_0000.
- Complete 9/4, then 5/0 → done and div_zero after 1 cycle, busy never rises, quotient/remainder still 2/1.
- start pulsed at cycle 10 of an in-flight divide → ignored, original result unchanged. A new start in the done cycle completes 33 cycles later.
- reset at cycle 15 of a divide → busy 0, outputs 0, no done pulse. A following 0xFFFF_FFFF / 1 unsigned returns 0xFFFF_FFFF, 0.
